// File: rtl/lfsr_prng_gen.sv
// Parametrised Fibonacci/Galois LFSR generator with a valid/ready output stream,
// runtime reseeding, zero-state recovery and a period monitor.
module lfsr_prng_gen #(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
    parameter logic [WIDTH-1:0] SEED  = 16'hACE1,
    parameter int unsigned      MODE  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic             seed_err,
    output logic             lockup,
    output logic             wrap,
    output logic [WIDTH-1:0] step_cnt
);

    typedef enum logic [1:0] {StInit, StRun, StHold, StLoad} fsm_e;

    fsm_e             fsm_q, fsm_d, run_next;
    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] seed_reg_q, seed_reg_d;
    logic [WIDTH-1:0] step_cnt_q, step_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic             seed_err_q, seed_err_d;
    logic             lockup_q, lockup_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] lfsr_next;
    logic [WIDTH-1:0] load_val;
    logic             step;

    always_comb begin
        if (MODE == 0) begin
            lfsr_next = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
        end else begin
            lfsr_next = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
        end
    end

    assign run_next = en ? StRun : StHold;
    assign load_val = (seed_in == '0) ? SEED : seed_in;
    assign step     = (fsm_q == StRun) && out_valid_q && out_ready;

    always_comb begin
        fsm_d      = fsm_q;
        state_d    = state_q;
        seed_reg_d = seed_reg_q;
        step_cnt_d = step_cnt_q;
        seed_err_d = 1'b0;
        lockup_d   = 1'b0;
        wrap_d     = 1'b0;
        if (fsm_q == StInit) begin
            fsm_d = run_next;
        end else if (seed_load) begin
            // A reload wins over a same-cycle handshake; that handshake is not an advance.
            fsm_d      = StLoad;
            state_d    = load_val;
            seed_reg_d = load_val;
            step_cnt_d = '0;
            seed_err_d = (seed_in == '0);
        end else begin
            fsm_d = run_next;
            if (fsm_q != StLoad && state_q == '0) begin
                state_d    = SEED;
                step_cnt_d = '0;
                lockup_d   = 1'b1;
            end else if (step) begin
                state_d = lfsr_next;
                if (lfsr_next == seed_reg_q) begin
                    wrap_d     = 1'b1;
                    step_cnt_d = '0;
                end else begin
                    step_cnt_d = step_cnt_q + 1'b1;
                end
            end
        end
        out_valid_d = (fsm_d == StRun);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q       <= StInit;
            state_q     <= SEED;
            seed_reg_q  <= SEED;
            step_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            seed_err_q  <= 1'b0;
            lockup_q    <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            seed_reg_q  <= seed_reg_d;
            step_cnt_q  <= step_cnt_d;
            out_valid_q <= out_valid_d;
            seed_err_q  <= seed_err_d;
            lockup_q    <= lockup_d;
            wrap_q      <= wrap_d;
        end
    end

    assign q         = state_q;
    assign out_valid = out_valid_q;
    assign seed_err  = seed_err_q;
    assign lockup    = lockup_q;
    assign wrap      = wrap_q;
    assign step_cnt  = step_cnt_q;

endmodule

// File: tb/tb_lfsr_prng_gen.sv
// Bench for lfsr_prng_gen: five builds (16-bit Fibonacci/Galois, 4-bit Fibonacci/Galois,
// zero-tap 16-bit) driven from shared stimulus, with a queue of predicted stream values.
module tb_lfsr_prng_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, out_ready, seed_load;
    logic [15:0] seed_in;

    logic [15:0] q_f, q_g, q_l, cnt_f, cnt_g, cnt_l;
    logic [3:0]  q_f4, q_g4, cnt_f4, cnt_g4;
    logic        ov_f, ov_g, ov_f4, ov_g4, ov_l;
    logic        serr_f, serr_g, serr_f4, serr_g4, serr_l;
    logic        lk_f, lk_g, lk_f4, lk_g4, lk_l;
    logic        wr_f, wr_g, wr_f4, wr_g4, wr_l;

    int n_pass = 0;
    int n_checks = 0;

    typedef struct packed {
        logic [15:0] qf;
        logic [15:0] qg;
        logic [15:0] cnt;
    } exp_t;
    exp_t sb[$];
    logic [15:0] m_f, m_g, m_cnt;

    lfsr_prng_gen dut_f (
        .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed_in(seed_in),
        .out_valid(ov_f), .out_ready(out_ready), .q(q_f), .seed_err(serr_f),
        .lockup(lk_f), .wrap(wr_f), .step_cnt(cnt_f)
    );
    lfsr_prng_gen #(.MODE(1)) dut_g (
        .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed_in(seed_in),
        .out_valid(ov_g), .out_ready(out_ready), .q(q_g), .seed_err(serr_g),
        .lockup(lk_g), .wrap(wr_g), .step_cnt(cnt_g)
    );
    lfsr_prng_gen #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .MODE(0)) dut_f4 (
        .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed_in(seed_in[3:0]),
        .out_valid(ov_f4), .out_ready(out_ready), .q(q_f4), .seed_err(serr_f4),
        .lockup(lk_f4), .wrap(wr_f4), .step_cnt(cnt_f4)
    );
    lfsr_prng_gen #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .MODE(1)) dut_g4 (
        .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed_in(seed_in[3:0]),
        .out_valid(ov_g4), .out_ready(out_ready), .q(q_g4), .seed_err(serr_g4),
        .lockup(lk_g4), .wrap(wr_g4), .step_cnt(cnt_g4)
    );
    lfsr_prng_gen #(.TAPS(16'h0000)) dut_l (
        .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed_in(seed_in),
        .out_valid(ov_l), .out_ready(out_ready), .q(q_l), .seed_err(serr_l),
        .lockup(lk_l), .wrap(wr_l), .step_cnt(cnt_l)
    );

    // Reference polynomials written directly from x^16+x^14+x^13+x^11+1 and x^4+x^3+1.
    function automatic logic [15:0] fib16(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction
    function automatic logic [15:0] gal16(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction
    function automatic logic [3:0] fib4(input logic [3:0] s);
        return {s[2:0], s[3] ^ s[2]};
    endfunction
    function automatic logic [3:0] gal4(input logic [3:0] s);
        return s[0] ? ((s >> 1) ^ 4'hC) : (s >> 1);
    endfunction

    task automatic run_stream(input int n, input logic rdy);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e = sb.pop_front();
            n_checks++; if (q_f !== e.qf) $display("FAIL stream_fib_q got %h want %h", q_f, e.qf); else n_pass++;
            n_checks++; if (q_g !== e.qg) $display("FAIL stream_gal_q got %h want %h", q_g, e.qg); else n_pass++;
            n_checks++; if (cnt_f !== e.cnt) $display("FAIL stream_cnt got %0d want %0d", cnt_f, e.cnt); else n_pass++;
            n_checks++; if (ov_f !== 1'b1) $display("FAIL stream_valid got %b want 1", ov_f); else n_pass++;
            out_ready = rdy;
            if (rdy) begin
                m_f = fib16(m_f);
                m_g = gal16(m_g);
                m_cnt = m_cnt + 16'd1;
            end
            sb.push_back('{qf: m_f, qg: m_g, cnt: m_cnt});
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b1; out_ready = 1'b1; seed_load = 1'b0; seed_in = 16'h0;
        repeat (2) @(negedge clk);
        n_checks++; if (q_f !== 16'hACE1) $display("FAIL reset_q_fib got %h want ace1", q_f); else n_pass++;
        n_checks++; if (q_g !== 16'hACE1) $display("FAIL reset_q_gal got %h want ace1", q_g); else n_pass++;
        n_checks++; if (q_f4 !== 4'h1) $display("FAIL reset_q_w4 got %h want 1", q_f4); else n_pass++;
        n_checks++; if (ov_f !== 1'b0) $display("FAIL reset_valid got %b want 0", ov_f); else n_pass++;
        n_checks++; if ({serr_f, lk_f, wr_f} !== 3'b000) $display("FAIL reset_pulses got %b want 000", {serr_f, lk_f, wr_f}); else n_pass++;
        n_checks++; if (cnt_f !== 16'h0) $display("FAIL reset_cnt got %0d want 0", cnt_f); else n_pass++;
    endtask

    task automatic test_stream();
        sb.delete();
        m_f = 16'hACE1; m_g = 16'hACE1; m_cnt = 16'h0;
        sb.push_back('{qf: m_f, qg: m_g, cnt: m_cnt});
        rst = 1'b1;
        @(negedge clk);
        run_stream(1, 1'b1);
        n_checks++; if (q_f !== 16'h59C3) $display("FAIL first_step_fib got %h want 59c3", q_f); else n_pass++;
        n_checks++; if (q_g !== 16'hE270) $display("FAIL first_step_gal got %h want e270", q_g); else n_pass++;
        run_stream(6, 1'b0);
        run_stream(8, 1'b1);
        run_stream(3, 1'b0);
        run_stream(4, 1'b1);
        sb.delete();
    endtask

    task automatic test_enable();
        n_checks++; if (q_f !== m_f) $display("FAIL en_start_q got %h want %h", q_f, m_f); else n_pass++;
        out_ready = 1'b0; en = 1'b0;
        @(negedge clk);
        n_checks++; if (ov_f !== 1'b0) $display("FAIL en_low_valid got %b want 0", ov_f); else n_pass++;
        n_checks++; if (q_f !== m_f) $display("FAIL en_low_q got %h want %h", q_f, m_f); else n_pass++;
        @(negedge clk);
        n_checks++; if (q_g !== m_g) $display("FAIL en_hold_q got %h want %h", q_g, m_g); else n_pass++;
        en = 1'b1;
        @(negedge clk);
        n_checks++; if (ov_f !== 1'b1) $display("FAIL en_high_valid got %b want 1", ov_f); else n_pass++;
        n_checks++; if (q_f !== m_f) $display("FAIL en_high_q got %h want %h", q_f, m_f); else n_pass++;
    endtask

    task automatic test_seed_load();
        seed_load = 1'b1; seed_in = 16'h0000; out_ready = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
        n_checks++; if (q_f !== 16'hACE1) $display("FAIL zero_seed_q got %h want ace1", q_f); else n_pass++;
        n_checks++; if (serr_f !== 1'b1) $display("FAIL zero_seed_err got %b want 1", serr_f); else n_pass++;
        n_checks++; if (ov_f !== 1'b0) $display("FAIL load_valid got %b want 0", ov_f); else n_pass++;
        n_checks++; if (cnt_f !== 16'h0) $display("FAIL zero_seed_cnt got %0d want 0", cnt_f); else n_pass++;
        @(negedge clk);
        n_checks++; if (q_f !== 16'hACE1) $display("FAIL after_load_q got %h want ace1", q_f); else n_pass++;
        n_checks++; if (ov_f !== 1'b1) $display("FAIL after_load_valid got %b want 1", ov_f); else n_pass++;
        n_checks++; if (serr_f !== 1'b0) $display("FAIL seed_err_width got %b want 0", serr_f); else n_pass++;
        seed_load = 1'b1; seed_in = 16'h1234;
        @(negedge clk);
        seed_load = 1'b0;
        n_checks++; if (q_f !== 16'h1234) $display("FAIL load_fib_q got %h want 1234", q_f); else n_pass++;
        n_checks++; if (q_g !== 16'h1234) $display("FAIL load_gal_q got %h want 1234", q_g); else n_pass++;
        n_checks++; if (serr_f !== 1'b0) $display("FAIL load_no_err got %b want 0", serr_f); else n_pass++;
        n_checks++; if (cnt_f !== 16'h0) $display("FAIL load_cnt got %0d want 0", cnt_f); else n_pass++;
        @(negedge clk);
        n_checks++; if (q_f !== 16'h1234) $display("FAIL load_no_extra_step got %h want 1234", q_f); else n_pass++;
        @(negedge clk);
        n_checks++; if (q_f !== fib16(16'h1234)) $display("FAIL load_step_fib got %h want %h", q_f, fib16(16'h1234)); else n_pass++;
        n_checks++; if (q_g !== gal16(16'h1234)) $display("FAIL load_step_gal got %h want %h", q_g, gal16(16'h1234)); else n_pass++;
        n_checks++; if (cnt_f !== 16'd1) $display("FAIL load_step_cnt got %0d want 1", cnt_f); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [3:0]  mf, mg;
        logic [15:0] seen_f, seen_g;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1; en = 1'b1; out_ready = 1'b1; seed_load = 1'b0;
        @(negedge clk);
        mf = 4'h1; mg = 4'h1; seen_f = '0; seen_g = '0;
        for (int i = 0; i <= 15; i++) begin
            n_checks++; if (q_f4 !== mf) $display("FAIL w4_fib_q[%0d] got %h want %h", i, q_f4, mf); else n_pass++;
            n_checks++; if (q_g4 !== mg) $display("FAIL w4_gal_q[%0d] got %h want %h", i, q_g4, mg); else n_pass++;
            n_checks++; if (cnt_f4 !== 4'((i == 15) ? 0 : i)) $display("FAIL w4_fib_cnt[%0d] got %0d", i, cnt_f4); else n_pass++;
            n_checks++; if (cnt_g4 !== 4'((i == 15) ? 0 : i)) $display("FAIL w4_gal_cnt[%0d] got %0d", i, cnt_g4); else n_pass++;
            n_checks++; if (wr_f4 !== (i == 15)) $display("FAIL w4_fib_wrap[%0d] got %b", i, wr_f4); else n_pass++;
            n_checks++; if (wr_g4 !== (i == 15)) $display("FAIL w4_gal_wrap[%0d] got %b", i, wr_g4); else n_pass++;
            if (i < 15) begin
                seen_f[q_f4] = 1'b1;
                seen_g[q_g4] = 1'b1;
            end
            mf = fib4(mf);
            mg = gal4(mg);
            @(negedge clk);
        end
        n_checks++; if (seen_f !== 16'hFFFE) $display("FAIL w4_fib_cover got %h want fffe", seen_f); else n_pass++;
        n_checks++; if (seen_g !== 16'hFFFE) $display("FAIL w4_gal_cover got %h want fffe", seen_g); else n_pass++;
    endtask

    task automatic test_lockup();
        logic [15:0] ml;
        logic        exp_lk;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        ml = 16'hACE1; exp_lk = 1'b0;
        for (int i = 0; i < 20; i++) begin
            n_checks++; if (q_l !== ml) $display("FAIL lock_q[%0d] got %h want %h", i, q_l, ml); else n_pass++;
            n_checks++; if (lk_l !== exp_lk) $display("FAIL lock_pulse[%0d] got %b want %b", i, lk_l, exp_lk); else n_pass++;
            if (exp_lk) begin
                n_checks++; if (cnt_l !== 16'h0) $display("FAIL lock_cnt got %0d want 0", cnt_l); else n_pass++;
            end
            if (ml == 16'h0) begin
                ml = 16'hACE1; exp_lk = 1'b1;
            end else begin
                ml = ml << 1; exp_lk = 1'b0;
            end
            @(negedge clk);
        end
        // Asynchronous reset between clock edges must take effect without a clock.
        #2 rst = 1'b0;
        #1;
        n_checks++; if (q_f !== 16'hACE1) $display("FAIL async_rst_q got %h want ace1", q_f); else n_pass++;
        n_checks++; if (q_g !== 16'hACE1) $display("FAIL async_rst_q_gal got %h want ace1", q_g); else n_pass++;
        n_checks++; if (ov_f !== 1'b0) $display("FAIL async_rst_valid got %b want 0", ov_f); else n_pass++;
        n_checks++; if (cnt_f !== 16'h0) $display("FAIL async_rst_cnt got %0d want 0", cnt_f); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        test_reset();
        test_stream();
        test_enable();
        test_seed_load();
        test_wrap();
        test_lockup();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
